// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, region states and RGB565 bar colours for the 800x480 LCD timing block.
package lcd_timing_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FRONT_DEF  = 40;
    localparam int H_SYNC_DEF   = 48;
    localparam int H_BACK_DEF   = 40;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 13;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BACK_DEF   = 29;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } region_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Eight 100-pixel-wide bars across the visible line.
    function automatic logic [15:0] bar_colour(input logic [9:0] i_x);
        logic [15:0] colour;
        if      (i_x < 10'd100) colour = RGB_WHITE;
        else if (i_x < 10'd200) colour = RGB_YELLOW;
        else if (i_x < 10'd300) colour = RGB_CYAN;
        else if (i_x < 10'd400) colour = RGB_GREEN;
        else if (i_x < 10'd500) colour = RGB_MAGENTA;
        else if (i_x < 10'd600) colour = RGB_RED;
        else if (i_x < 10'd700) colour = RGB_BLUE;
        else                    colour = RGB_BLACK;
        return colour;
    endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// Single-axis position counter with its region FSM (used once per axis).
//   state     | meaning
//   ST_ACTIVE | cnt in visible region
//   ST_FRONT  | cnt in front porch
//   ST_SYNC   | cnt in sync pulse
//   ST_BACK   | cnt in back porch
module lcd_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter int ACTIVE = 800,
    parameter int FRONT  = 40,
    parameter int SYNC   = 48,
    parameter int BACK   = 40,
    parameter int CW     = 11
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output region_t       o_state
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [CW-1:0] L_ACT_LAST = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] L_FRT_LAST = CW'(ACTIVE + FRONT - 1);
    localparam logic [CW-1:0] L_SYN_LAST = CW'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CW-1:0] L_LAST     = CW'(TOTAL - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    region_t       r_state;
    region_t       w_state_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_state <= ST_ACTIVE;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Region changes only on the last count of the current region.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        if (i_en) begin
            w_cnt_nxt = (r_cnt == L_LAST) ? '0 : r_cnt + CW'(1);
            case (r_state)
                ST_ACTIVE: if (r_cnt == L_ACT_LAST) w_state_nxt = ST_FRONT;
                ST_FRONT:  if (r_cnt == L_FRT_LAST) w_state_nxt = ST_SYNC;
                ST_SYNC:   if (r_cnt == L_SYN_LAST) w_state_nxt = ST_BACK;
                ST_BACK:   if (r_cnt == L_LAST)     w_state_nxt = ST_ACTIVE;
                default:   w_state_nxt = ST_ACTIVE;
            endcase
        end
    end

    assign o_cnt   = r_cnt;
    assign o_state = r_state;

endmodule

// File: rtl/lcd_800_480_timing.sv
// 800x480 LCD raster timing generator with registered sync/de/coordinate outputs.
// Optional colour-bar pattern on rgb when LCD_TIMING_TEST_PATTERN_EN is defined.
module lcd_800_480_timing
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int H_FRONT         = H_FRONT_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BACK          = H_BACK_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int V_FRONT         = V_FRONT_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BACK          = V_BACK_DEF,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic [15:0] rgb
);

    localparam int   L_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam logic L_SYNC_ON = ~SYNC_ACTIVE_LOW;

    logic [10:0] w_h_cnt;
    logic [9:0]  w_v_cnt;
    region_t     w_h_state;
    region_t     w_v_state;
    logic        w_h_wrap;
    logic        w_v_en;
    logic        w_active;

    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic        r_frame_start;

    assign w_h_wrap = (w_h_cnt == 11'(L_H_TOTAL - 1));
    assign w_v_en   = pix_en & w_h_wrap;
    assign w_active = (w_h_state == ST_ACTIVE) && (w_v_state == ST_ACTIVE);

    lcd_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .CW     (11)
    ) u_h_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (pix_en),
        .o_cnt   (w_h_cnt),
        .o_state (w_h_state)
    );

    lcd_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .CW     (10)
    ) u_v_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_v_en),
        .o_cnt   (w_v_cnt),
        .o_state (w_v_state)
    );

    // Outputs describe the counter state of the previous enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsync       <= ~L_SYNC_ON;
            r_vsync       <= ~L_SYNC_ON;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_hsync       <= (w_h_state == ST_SYNC) ? L_SYNC_ON : ~L_SYNC_ON;
            r_vsync       <= (w_v_state == ST_SYNC) ? L_SYNC_ON : ~L_SYNC_ON;
            r_de          <= w_active;
            r_x           <= w_active ? w_h_cnt : '0;
            r_y           <= w_active ? w_v_cnt : '0;
            r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
        end
    end

`ifdef LCD_TIMING_TEST_PATTERN_EN
    logic [15:0] r_rgb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rgb <= '0;
        end else if (pix_en) begin
            r_rgb <= w_active ? bar_colour(w_h_cnt[9:0]) : '0;
        end
    end

    assign rgb = r_rgb;
`else
    assign rgb = '0;
`endif

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_frame_start;

endmodule
